button_event_scheduler: RTL

- Sequences N debounced button/switch levels into a single serialized event stream for the host.
- Each channel has press/release/long-press tracking on a shared 1 ms timebase.
- Events go into a one-entry per-channel pending slot and are drained round-robin through a valid/ready output register.
- Sits directly after the per-button antibounce instances, in front of the CSR/interrupt logic.

---
 rtl/btn_evt_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/button_event_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// rtl/btn_evt_pkg.sv - shared event/state types and widths for the button event scheduler
package btn_evt_pkg;

   typedef enum logic [1:0] {
      PRESS   = 2'd0,
      RELEASE = 2'd1,
      LONG    = 2'd2,
      REPEAT  = 2'd3
   } evt_type_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HELD     = 2'd1,
      LONGHELD = 2'd2
   } ch_state_e;

   // Hold counters count 1 ms ticks; wide enough for the longest LONG_MS.
   localparam int HOLD_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with rotating pointer, one-hot and index grant
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 en,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_any
);

   localparam int W = $clog2(N);

   logic [W-1:0] ptr;

   // First requester at or after the pointer, wrapping modulo N; nothing granted while en is low.
   always_comb begin : search
      int j;
      j       = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (en && !gnt_any && req[j]) begin
            gnt_any = 1'b1;
            gnt_idx = W'(j);
            gnt[j]  = 1'b1;
         end
      end
   end

   // After a grant the search restarts just past the winner; otherwise the pointer holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (gnt_any) begin
         ptr <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/button_event_scheduler.sv
// rtl/button_event_scheduler.sv - serializes per-button PRESS/RELEASE/LONG events (BTN_AUTOREPEAT_EN adds REPEAT)
module button_event_scheduler #(
   parameter int N_BTN     = 4,
   parameter int FREQ      = 25,
   parameter int LONG_MS   = 1000,
   parameter int REPEAT_MS = 200
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_BTN-1:0]         i_btn,
   output logic                     o_evt_valid,
   input  logic                     i_evt_ready,
   output logic [$clog2(N_BTN)-1:0] o_evt_id,
   output logic [1:0]               o_evt_type,
   output logic [N_BTN-1:0]         o_pending,
   output logic                     o_drop
);

   import btn_evt_pkg::*;

   localparam int ID_W   = $clog2(N_BTN);
   localparam int TICK_P = FREQ * 1000;
   localparam int TC_W   = $clog2(TICK_P);

   logic [N_BTN-1:0]      btn_r;
   logic [N_BTN-1:0]      btn_prev;
   logic [TC_W-1:0]       tick_cnt;
   logic                  tick;
   ch_state_e             state     [N_BTN];
   ch_state_e             state_nxt [N_BTN];
   logic [HOLD_CNT_W-1:0] cnt       [N_BTN];
   logic [HOLD_CNT_W-1:0] cnt_nxt   [N_BTN];
   logic [N_BTN-1:0]      ev_new;
   evt_type_e             ev_type   [N_BTN];
   logic [N_BTN-1:0]      pend;
   evt_type_e             pend_type [N_BTN];
   logic                  load;
   logic [N_BTN-1:0]      gnt;
   logic [ID_W-1:0]       gnt_idx;
   logic                  gnt_any;

   assign tick      = (tick_cnt == TC_W'(TICK_P - 1));
   assign load      = !o_evt_valid || i_evt_ready;
   assign o_pending = pend;

   // Free-running 1 ms prescaler shared by every channel.
   always_ff @(posedge clk) begin
      if (rst) tick_cnt <= '0;
      else     tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
   end

   // Register the levels once more so edges are seen one cycle after the input changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_r    <= '0;
         btn_prev <= '0;
      end else begin
         btn_r    <= i_btn;
         btn_prev <= btn_r;
      end
   end

   // Per-channel event decode; a falling edge is checked first so it beats a LONG on the same tick.
   always_comb begin
      for (int i = 0; i < N_BTN; i++) begin
         state_nxt[i] = state[i];
         cnt_nxt[i]   = cnt[i];
         ev_new[i]    = 1'b0;
         ev_type[i]   = PRESS;
         case (state[i])
            IDLE: begin
               if (btn_r[i] && !btn_prev[i]) begin
                  ev_new[i]    = 1'b1;
                  ev_type[i]   = PRESS;
                  state_nxt[i] = HELD;
                  cnt_nxt[i]   = '0;
               end
            end
            HELD: begin
               if (!btn_r[i] && btn_prev[i]) begin
                  ev_new[i]    = 1'b1;
                  ev_type[i]   = RELEASE;
                  state_nxt[i] = IDLE;
               end else if (tick) begin
                  if (cnt[i] == HOLD_CNT_W'(LONG_MS - 1)) begin
                     ev_new[i]    = 1'b1;
                     ev_type[i]   = LONG;
                     state_nxt[i] = LONGHELD;
                     cnt_nxt[i]   = '0;
                  end else begin
                     cnt_nxt[i] = cnt[i] + 1'b1;
                  end
               end
            end
            LONGHELD: begin
               if (!btn_r[i] && btn_prev[i]) begin
                  ev_new[i]    = 1'b1;
                  ev_type[i]   = RELEASE;
                  state_nxt[i] = IDLE;
               end else if (tick) begin
`ifdef BTN_AUTOREPEAT_EN
                  if (cnt[i] == HOLD_CNT_W'(REPEAT_MS - 1)) begin
                     ev_new[i]  = 1'b1;
                     ev_type[i] = REPEAT;
                     cnt_nxt[i] = '0;
                  end else begin
                     cnt_nxt[i] = cnt[i] + 1'b1;
                  end
`else
                  if (cnt[i] != {HOLD_CNT_W{1'b1}}) cnt_nxt[i] = cnt[i] + 1'b1;
`endif
               end
            end
            default: state_nxt[i] = IDLE;
         endcase
      end
   end

`ifndef BTN_AUTOREPEAT_EN
   // REPEAT_MS has no effect in this build.
   if (REPEAT_MS < 0) begin : g_repeat_unused
   end
`endif

   // Channel state and hold counters.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_BTN; i++) begin
         if (rst) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
         end else begin
            state[i] <= state_nxt[i];
            cnt[i]   <= cnt_nxt[i];
         end
      end
   end

   rr_arbiter #(.N(N_BTN)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (pend),
      .en      (load),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // Pending slots and output register; a new event wins over a same-cycle grant of its slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend        <= '0;
         o_drop      <= 1'b0;
         o_evt_valid <= 1'b0;
         o_evt_id    <= '0;
         o_evt_type  <= '0;
         for (int i = 0; i < N_BTN; i++) pend_type[i] <= PRESS;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (ev_new[i]) begin
               pend[i]      <= 1'b1;
               pend_type[i] <= ev_type[i];
            end else if (gnt[i]) begin
               pend[i] <= 1'b0;
            end
         end
         o_drop <= |(ev_new & pend & ~gnt);
         if (load) begin
            o_evt_valid <= gnt_any;
            if (gnt_any) begin
               o_evt_id   <= gnt_idx;
               o_evt_type <= pend_type[gnt_idx];
            end
         end
      end
   end

endmodule
